// File: rtl/reg_sync_arbiter_if.sv
// Bus bundle between register-write sources, the arbiter and the four-phase
// req/ack crossing channel. Source k occupies slice [k*W +: W] of i_addr/i_data.
interface reg_sync_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]                 i_req;
  logic [NUM_REQ*ADDR_WIDTH-1:0]      i_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]      i_data;
  logic [NUM_REQ-1:0]                 o_grant;
  logic                               o_xfer_req;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0]   o_xfer_word;
  logic                               i_xfer_ack;
  logic                               o_busy;
  logic                               o_timeout;
  logic [7:0]                         o_err_count;

  modport master (
    input  i_req, i_addr, i_data, i_xfer_ack,
    output o_grant, o_xfer_req, o_xfer_word, o_busy, o_timeout, o_err_count
  );

  modport slave (
    output i_req, i_addr, i_data, i_xfer_ack,
    input  o_grant, o_xfer_req, o_xfer_word, o_busy, o_timeout, o_err_count
  );
endinterface

// File: rtl/reg_sync_arbiter.sv
// Round-robin arbiter feeding one four-phase req/ack crossing channel, with an
// acknowledge watchdog and a saturating timeout counter.
module reg_sync_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  reg_sync_arbiter_if.master bus
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int WD_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH;
  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W:0]   NREQ_EXT  = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] NREQ_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [WD_W-1:0]     wd;
  logic [PTR_W-1:0]    winner;
  logic                found;
  logic [PTR_W:0]      cand;
  logic [WORD_W-1:0]   sel_word;

  logic [NUM_REQ-1:0]  grant_q;
  logic                xfer_req_q;
  logic [WORD_W-1:0]   word_q;
  logic                busy_q;
  logic                timeout_q;
  logic [7:0]          err_q;

  // First pending source at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= NREQ_EXT) cand = cand - NREQ_EXT;
      if (!found && bus.i_req[cand[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (PTR_W'(k) == winner)
        sel_word = {bus.i_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
                    bus.i_data[k*DATA_WIDTH +: DATA_WIDTH]};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      ptr        <= '0;
      wd         <= '0;
      grant_q    <= '0;
      xfer_req_q <= 1'b0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      grant_q   <= '0;
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          // Ack-low guard keeps a stale post-reset ack from completing a new request.
          if (found && !bus.i_xfer_ack) begin
            state      <= REQ;
            word_q     <= sel_word;
            grant_q    <= NUM_REQ'(1) << winner;
            ptr        <= (winner == NREQ_LAST) ? '0 : winner + 1'b1;
            wd         <= '0;
            xfer_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        REQ: begin
          if (bus.i_xfer_ack) begin
            state      <= RELEASE;
            xfer_req_q <= 1'b0;
          end else if (TIMEOUT != 0 && wd == WD_LAST) begin
            state      <= RELEASE;
            xfer_req_q <= 1'b0;
            timeout_q  <= 1'b1;
            if (err_q != 8'hFF) err_q <= err_q + 8'd1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        RELEASE: begin
          if (!bus.i_xfer_ack) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_xfer_req  = xfer_req_q;
  assign bus.o_xfer_word = word_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_err_count = err_q;

endmodule

// File: tb/tb_reg_sync_arbiter.sv
// Scoreboard bench: stimulus pushes expected grants/timeouts from a
// transaction-level round-robin model; a negedge monitor pops and compares.
module tb_reg_sync_arbiter;
  localparam int N  = 4;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 8;

  typedef struct {
    logic [N-1:0]     g;
    logic [AW+DW-1:0] w;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  exp_t exp_q[$];
  int   to_q[$];
  exp_t mon_e;

  logic [N-1:0]  req;
  logic [AW-1:0] addr[N];
  logic [DW-1:0] data[N];
  int            rem[N];
  logic          ack;
  bit            auto_ack;
  int            ack_delay;
  int            ack_cnt;
  int            model_last;
  int            model_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_sync_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_sync_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Round robin: each pending source is served in order after the last one served.
  function automatic void model_push();
    int   r[N];
    int   left;
    exp_t e;
    left = 0;
    for (int k = 0; k < N; k++) begin
      r[k] = req[k] ? rem[k] : 0;
      left += r[k];
    end
    while (left > 0) begin
      for (int i = 1; i <= N; i++) begin
        int k;
        k = (model_last + i) % N;
        if (r[k] > 0) begin
          e.g = N'(1) << k;
          e.w = {addr[k], data[k]};
          exp_q.push_back(e);
          r[k]--;
          left--;
          model_last = k;
          break;
        end
      end
    end
  endfunction

  task automatic apply();
    bus.i_req      = req;
    bus.i_xfer_ack = ack;
    for (int k = 0; k < N; k++) begin
      bus.i_addr[k*AW +: AW] = addr[k];
      bus.i_data[k*DW +: DW] = data[k];
    end
  endtask

  // One cycle: sources drop after their last grant; optional ack responder.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      if (bus.o_grant[k] && rem[k] > 0) begin
        rem[k]--;
        if (rem[k] == 0) req[k] = 1'b0;
      end
    end
    if (auto_ack) begin
      if (!bus.o_xfer_req) begin
        ack     = 1'b0;
        ack_cnt = 0;
      end else if (!ack) begin
        if (ack_cnt >= ack_delay) ack = 1'b1;
        else ack_cnt++;
      end
    end
    apply();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(req == '0 && !bus.o_busy && !ack) && n < 400);
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL idle_wait: busy=%0b req=%0h expected idle within 400 cycles", bus.o_busy, req);
    end
  endtask

  task automatic set_src(input int k, input int count);
    req[k]  = 1'b1;
    rem[k]  = count;
    addr[k] = AW'($urandom);
    data[k] = DW'($urandom);
  endtask

  task automatic do_timeout();
    int k;
    k = $urandom_range(0, N-1);
    set_src(k, 1);
    model_push();
    to_q.push_back(cyc + 1 + TO);
    model_err = (model_err < 255) ? model_err + 1 : 255;
    apply();
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (bus.o_grant != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(bus.o_grant), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("grant", 32'(bus.o_grant), 32'(mon_e.g));
        check("word",  32'(bus.o_xfer_word), 32'(mon_e.w));
      end
    end
    if (bus.o_timeout) begin
      if (to_q.size() == 0) check("unexpected_timeout", 32'd1, 32'd0);
      else check("timeout_cycle", 32'(cyc), 32'(to_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    logic [N-1:0] mask;
    req = '0; ack = 1'b0; auto_ack = 1'b1; ack_delay = 2; ack_cnt = 0;
    model_last = -1; model_err = 0;
    for (int k = 0; k < N; k++) begin rem[k] = 0; addr[k] = '0; data[k] = '0; end
    apply();
    repeat (3) @(negedge clk);
    check("rst_xfer_req", 32'(bus.o_xfer_req), 32'd0);
    check("rst_busy",     32'(bus.o_busy), 32'd0);
    check("rst_word",     32'(bus.o_xfer_word), 32'd0);
    check("rst_err",      32'(bus.o_err_count), 32'd0);
    check("rst_grant",    32'(bus.o_grant), 32'd0);
    rst_n = 1'b1;
    tick();

    // All four requesting continuously for two rounds.
    for (int k = 0; k < N; k++) set_src(k, 2);
    model_push();
    apply();
    wait_idle();

    // Sources 1 and 3 after source 3 was last served.
    set_src(1, 1);
    set_src(3, 1);
    model_push();
    apply();
    wait_idle();

    // Single source, hand-driven ack.
    auto_ack = 1'b0;
    req[0] = 1'b1; rem[0] = 1; addr[0] = 4'h3; data[0] = 16'hBEEF;
    model_push();
    apply();
    c = cyc;
    tick();
    check("t1_xfer_req_on", 32'(bus.o_xfer_req), 32'd1);
    check("t1_busy_on",     32'(bus.o_busy), 32'd1);
    check("t1_word",        32'(bus.o_xfer_word), 32'h3BEEF);
    check("t1_grant_cycle", 32'(cyc), 32'(c + 1));
    tick();
    tick();
    check("t1_xfer_req_hold", 32'(bus.o_xfer_req), 32'd1);
    ack = 1'b1; apply();
    tick();
    check("t1_xfer_req_off", 32'(bus.o_xfer_req), 32'd0);
    check("t1_busy_release", 32'(bus.o_busy), 32'd1);
    ack = 1'b0; apply();
    tick();
    check("t1_busy_off", 32'(bus.o_busy), 32'd0);
    auto_ack = 1'b1;

    // Random batches.
    repeat (20) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++)
        if (mask[k]) set_src(k, $urandom_range(1, 3));
      ack_delay = $urandom_range(0, 6);
      model_push();
      apply();
      wait_idle();
    end

    // Watchdog: one timeout, then ack in the last REQ cycle, then one cycle late.
    auto_ack = 1'b0;
    do_timeout();
    check("err_after_one", 32'(bus.o_err_count), 32'(model_err));
    auto_ack = 1'b1; ack_delay = TO - 1;
    set_src($urandom_range(0, N-1), 1);
    model_push();
    apply();
    wait_idle();
    check("err_ack_at_limit", 32'(bus.o_err_count), 32'(model_err));
    ack_delay = TO;
    do_timeout();
    check("err_ack_late", 32'(bus.o_err_count), 32'(model_err));
    auto_ack = 1'b0;
    repeat (298) do_timeout();
    check("err_saturated", 32'(bus.o_err_count), 32'(model_err));

    // Reset during REQ with ack high.
    set_src(1, 1);
    model_push();
    apply();
    tick();
    tick();
    check("rst_mid_in_req", 32'(bus.o_xfer_req), 32'd1);
    set_src(0, 1);
    set_src(2, 1);
    ack = 1'b1;
    apply();
    rst_n = 1'b0;
    #1;
    check("rst_async_xfer_req", 32'(bus.o_xfer_req), 32'd0);
    check("rst_async_busy",     32'(bus.o_busy), 32'd0);
    check("rst_async_word",     32'(bus.o_xfer_word), 32'd0);
    check("rst_async_err",      32'(bus.o_err_count), 32'd0);
    check("rst_async_timeout",  32'(bus.o_timeout), 32'd0);
    model_last = -1;
    model_err  = 0;
    model_push();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      check("post_rst_no_req",  32'(bus.o_xfer_req), 32'd0);
      check("post_rst_no_busy", 32'(bus.o_busy), 32'd0);
    end
    ack = 1'b0; auto_ack = 1'b1; ack_cnt = 0; ack_delay = 1;
    apply();
    wait_idle();

    repeat (3) tick();
    check("exp_queue_drained",     32'(exp_q.size()), 32'd0);
    check("timeout_queue_drained", 32'(to_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
